// File: rtl/fp_to_int_vec.sv
// Multi-lane FP32 -> INT32/UINT32 converter with a stallable valid/ready pipeline.
// Conversion is done on the input beat and registered into stage 0; later stages only delay.
module fp_to_int_vec #(
  parameter int NUM_LANES  = 4,
  parameter int LATENCY    = 2,
  parameter int CTRL_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [32*NUM_LANES-1:0]   a_i,
  input  logic [2:0]                rm_i,
  input  logic                      unsigned_i,
  input  logic [NUM_LANES-1:0]      mask_i,
  input  logic [CTRL_WIDTH-1:0]     ctrl_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [32*NUM_LANES-1:0]   result_o,
  output logic [5*NUM_LANES-1:0]    fflags_o,
  output logic [4:0]                fflags_or_o,
  output logic [NUM_LANES-1:0]      mask_o,
  output logic [CTRL_WIDTH-1:0]     ctrl_o
);

  localparam int RW = 32 * NUM_LANES;
  localparam int FW = 5 * NUM_LANES;

  function automatic logic round_up(input logic s, input logic lsb, input logic g,
                                    input logic st, input logic [2:0] rm);
    logic up;
    case (rm)
      3'b001:  up = 1'b0;
      3'b010:  up = s & (g | st);
      3'b011:  up = ~s & (g | st);
      3'b100:  up = g;
      default: up = g & (st | lsb);
    endcase
    return up;
  endfunction

  // Returns {NV, NX, result}; NX is suppressed whenever NV fires.
  function automatic logic [33:0] saturate(input logic s, input logic uns, input logic big,
                                           input logic inexact, input logic [32:0] mag);
    logic        nv;
    logic [31:0] r;
    if (uns) begin
      if (s) begin
        nv = big | (mag != 33'd0);
        r  = 32'd0;
      end else begin
        nv = big | mag[32];
        r  = nv ? 32'hFFFF_FFFF : mag[31:0];
      end
    end else if (s) begin
      nv = big | (mag > 33'h0_8000_0000);
      r  = nv ? 32'h8000_0000 : (32'd0 - mag[31:0]);
    end else begin
      nv = big | (mag > 33'h0_7FFF_FFFF);
      r  = nv ? 32'h7FFF_FFFF : mag[31:0];
    end
    return {nv, ~nv & inexact, r};
  endfunction

  function automatic logic [33:0] cvt_lane(input logic [31:0] a, input logic [2:0] rm,
                                           input logic uns);
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    logic [7:0]  rsh;
    logic [63:0] ext;
    logic [32:0] mag;
    logic        g, st, big, inx;
    logic [33:0] out;
    s   = a[31];
    e   = a[30:23];
    m   = {|e, a[22:0]};
    big = 1'b0;
    inx = 1'b0;
    mag = '0;
    ext = '0;
    rsh = '0;
    g   = 1'b0;
    st  = 1'b0;
    if (e == 8'hFF) begin
      if ((a[22:0] != 23'd0) || !s) out = {2'b10, (uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF)};
      else                          out = {2'b10, (uns ? 32'h0000_0000 : 32'h8000_0000)};
    end else begin
      // e >= 159 means |x| >= 2^32, beyond either integer range.
      if (e >= 8'd159) begin
        big = 1'b1;
      end else if (e >= 8'd150) begin
        mag = {9'd0, m} << (e - 8'd150);
      end else begin
        rsh = (e == 8'd0) ? 8'd149 : (8'd150 - e);
        if (rsh > 8'd32) rsh = 8'd32;
        ext = {8'd0, m, 32'd0} >> rsh;
        g   = ext[31];
        st  = |ext[30:0];
        inx = g | st;
        mag = {1'b0, ext[63:32]} + {32'd0, round_up(s, ext[32], g, st, rm)};
      end
      out = saturate(s, uns, big, inx, mag);
    end
    return out;
  endfunction

  logic [RW-1:0]         res_d;
  logic [FW-1:0]         flg_d;
  logic [LATENCY-1:0]    vld_q;
  logic [LATENCY-1:0]    adv;
  logic [RW-1:0]         res_q [LATENCY];
  logic [FW-1:0]         flg_q [LATENCY];
  logic [NUM_LANES-1:0]  msk_q [LATENCY];
  logic [CTRL_WIDTH-1:0] ctl_q [LATENCY];

  always_comb begin
    logic [33:0] cv;
    cv    = '0;
    res_d = '0;
    flg_d = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (mask_i[k]) begin
        cv                = cvt_lane(a_i[32*k +: 32], rm_i, unsigned_i);
        res_d[32*k +: 32] = cv[31:0];
        flg_d[5*k +: 5]   = {cv[33], 3'b000, cv[32]};
      end
    end
  end

  // A stage may move when the output accepts or any stage at or after it is empty.
  always_comb begin
    logic full;
    full = 1'b1;
    adv  = '0;
    for (int s = LATENCY - 1; s >= 0; s--) begin
      full   = full & vld_q[s];
      adv[s] = out_ready_i | ~full;
    end
  end

  assign in_ready_o = adv[0] | ~rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        res_q[s] <= '0;
        flg_q[s] <= '0;
        msk_q[s] <= '0;
        ctl_q[s] <= '0;
      end
    end else begin
      // stage 0: converted beat
      if (adv[0]) begin
        vld_q[0] <= in_valid_i;
        res_q[0] <= res_d;
        flg_q[0] <= flg_d;
        msk_q[0] <= mask_i;
        ctl_q[0] <= ctrl_i;
      end
      // stages 1..LATENCY-1: delay registers
      for (int s = 1; s < LATENCY; s++) begin
        if (adv[s]) begin
          vld_q[s] <= vld_q[s-1];
          res_q[s] <= res_q[s-1];
          flg_q[s] <= flg_q[s-1];
          msk_q[s] <= msk_q[s-1];
          ctl_q[s] <= ctl_q[s-1];
        end
      end
    end
  end

  assign out_valid_o = vld_q[LATENCY-1];
  assign result_o    = res_q[LATENCY-1];
  assign fflags_o    = flg_q[LATENCY-1];
  assign mask_o      = msk_q[LATENCY-1];
  assign ctrl_o      = ctl_q[LATENCY-1];

  always_comb begin
    fflags_or_o = '0;
    for (int k = 0; k < NUM_LANES; k++) fflags_or_o = fflags_or_o | flg_q[LATENCY-1][5*k +: 5];
  end

endmodule

// File: tb/tb_fp_to_int_vec.sv
// Bench for fp_to_int_vec: a LATENCY=2 instance for directed/random single beats and a
// LATENCY=3 instance for streaming, backpressure and reset-drop, both against a real-arithmetic model.
module tb_fp_to_int_vec;

  localparam logic [31:0] F1P5  = 32'h3FC0_0000;
  localparam logic [31:0] FM2P5 = 32'hC020_0000;
  localparam logic [31:0] FNAN  = 32'h7FC0_0000;
  localparam logic [31:0] F2P31 = 32'h4F00_0000;
  localparam logic [31:0] FM1   = 32'hBF80_0000;
  localparam logic [31:0] FMQ   = 32'hBE80_0000;

  typedef struct {
    logic [127:0] res;
    logic [19:0]  flg;
    logic [4:0]   fo;
    logic [3:0]   msk;
    logic [15:0]  ctl;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         v2, v3, r2, r3;
  logic [127:0] a;
  logic [2:0]   rm;
  logic         uns;
  logic [3:0]   msk;
  logic [15:0]  ctl;

  logic         ir2, ov2, ir3, ov3;
  logic [127:0] res2, res3;
  logic [19:0]  flg2, flg3;
  logic [4:0]   fo2, fo3;
  logic [3:0]   mo2, mo3;
  logic [15:0]  co2, co3;

  int total = 0, passed = 0, fails = 0;
  logic [127:0] lres;
  logic [19:0]  lflg;
  logic [4:0]   lfo;
  logic [3:0]   lmo;
  logic [15:0]  lco;

  always #5 clk = ~clk;

  fp_to_int_vec #(.NUM_LANES(4), .LATENCY(2), .CTRL_WIDTH(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(v2), .in_ready_o(ir2), .a_i(a), .rm_i(rm),
    .unsigned_i(uns), .mask_i(msk), .ctrl_i(ctl), .out_valid_o(ov2), .out_ready_i(r2),
    .result_o(res2), .fflags_o(flg2), .fflags_or_o(fo2), .mask_o(mo2), .ctrl_o(co2));

  fp_to_int_vec #(.NUM_LANES(4), .LATENCY(3), .CTRL_WIDTH(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(v3), .in_ready_o(ir3), .a_i(a), .rm_i(rm),
    .unsigned_i(uns), .mask_i(msk), .ctrl_i(ctl), .out_valid_o(ov3), .out_ready_i(r3),
    .result_o(res3), .fflags_o(flg3), .fflags_or_o(fo3), .mask_o(mo3), .ctrl_o(co3));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact value as a real, rounded with floor/ceil arithmetic, then range-checked.
  function automatic void ref_lane(input logic [31:0] x, input logic [2:0] rmv, input logic u,
                                   output logic [31:0] r, output logic [4:0] fl);
    bit     s;
    int     e, f, ex;
    real    v, lo, d, mag;
    bit     odd, up, nv, nx;
    longint lv;
    s = x[31];
    e = int'(x[30:23]);
    f = int'(x[22:0]);
    if (e == 255) begin
      fl = 5'h10;
      if (f != 0 || !s) r = u ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      else              r = u ? 32'h0 : 32'h8000_0000;
      return;
    end
    v  = (e == 0) ? real'(f) : real'(f + 8388608);
    ex = (e == 0) ? -149 : e - 150;
    for (int i = 0; i < ex; i++) v = v * 2.0;
    for (int i = 0; i > ex; i--) v = v / 2.0;
    lo  = $floor(v);
    d   = v - lo;
    odd = ($floor(lo / 2.0) * 2.0 != lo);
    case (rmv)
      3'd1:    up = 1'b0;
      3'd2:    up = s && (d > 0.0);
      3'd3:    up = !s && (d > 0.0);
      3'd4:    up = (d >= 0.5);
      default: up = (d > 0.5) || (d == 0.5 && odd);
    endcase
    mag = up ? lo + 1.0 : lo;
    if (u) nv = s ? (mag > 0.0) : (mag > 4294967295.0);
    else   nv = s ? (mag > 2147483648.0) : (mag > 2147483647.0);
    nx = !nv && (mag != v);
    if (nv) begin
      if (u) r = s ? 32'h0 : 32'hFFFF_FFFF;
      else   r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      lv = longint'(mag);
      if (s) lv = -lv;
      r = u ? (s ? 32'h0 : lv[31:0]) : lv[31:0];
    end
    fl = {nv, 3'b000, nx};
  endfunction

  function automatic beat_t model(input logic [127:0] av, input logic [2:0] rmv, input logic u,
                                  input logic [3:0] mv, input logic [15:0] cv);
    beat_t       b;
    logic [31:0] r;
    logic [4:0]  fl;
    b.res = '0; b.flg = '0; b.fo = '0; b.msk = mv; b.ctl = cv;
    for (int k = 0; k < 4; k++) begin
      if (mv[k]) begin
        ref_lane(av[32*k +: 32], rmv, u, r, fl);
        b.res[32*k +: 32] = r;
        b.flg[5*k +: 5]   = fl;
        b.fo              = b.fo | fl;
      end
    end
    return b;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    case ($urandom_range(0, 15))
      0: case ($urandom_range(0, 5))
           0: r = 32'h0000_0000;
           1: r = 32'h8000_0000;
           2: r = 32'h7F80_0000;
           3: r = 32'hFF80_0000;
           4: r = FNAN;
           default: r = {1'($urandom_range(0, 1)), 8'd0, 23'($urandom)};
         endcase
      1: r = {1'($urandom_range(0, 1)), 8'($urandom_range(126, 130)), 3'($urandom_range(0, 7)), 20'd0};
      default: r = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 162)), 23'($urandom)};
    endcase
    return r;
  endfunction

  task automatic drive_rand(input logic [15:0] tag, output beat_t b);
    a   = {rand_fp(), rand_fp(), rand_fp(), rand_fp()};
    rm  = 3'($urandom_range(0, 7));
    uns = 1'($urandom_range(0, 1));
    msk = 4'($urandom_range(0, 15));
    ctl = tag;
    b   = model(a, rm, uns, msk, ctl);
  endtask

  // One beat through the LATENCY=2 instance with out_ready held high.
  task automatic send2(input logic [127:0] av, input logic [2:0] rmv, input logic u,
                       input logic [3:0] mv, input logic [15:0] cv, input string tag);
    beat_t e;
    e = model(av, rmv, u, mv, cv);
    @(posedge clk); #1;
    a = av; rm = rmv; uns = u; msk = mv; ctl = cv; v2 = 1'b1;
    @(negedge clk); chk({tag, ".rdy"}, ir2, 1'b1);
    @(posedge clk); #1 v2 = 1'b0;
    @(negedge clk); chk({tag, ".lat1"}, ov2, 1'b0);
    @(posedge clk);
    @(negedge clk); chk({tag, ".lat2"}, ov2, 1'b1);
    chk({tag, ".res"}, res2, e.res);
    chk({tag, ".flg"}, flg2, e.flg);
    chk({tag, ".for"}, fo2, e.fo);
    chk({tag, ".msk"}, mo2, e.msk);
    chk({tag, ".ctl"}, co2, e.ctl);
    lres = res2; lflg = flg2; lfo = fo2; lmo = mo2; lco = co2;
  endtask

  // Streams nb random beats through the LATENCY=3 instance, optionally stalling the output.
  task automatic stream3(input int nb, input int st0, input int stn, input bit rnd,
                         input logic [15:0] tag0, input string tag);
    beat_t q[$];
    beat_t cur;
    int    sent = 0, got = 0, cyc = 0;
    logic  ir, ov;
    @(posedge clk); #1;
    drive_rand(tag0, cur);
    v3 = 1'b1;
    while (got < nb && cyc < 400) begin
      r3 = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= st0 && cyc < st0 + stn);
      @(negedge clk);
      ir = ir3;
      ov = ov3;
      chk({tag, ".rdy"}, ir, (q.size() < 3) || r3);
      if (ov) begin
        if (q.size() == 0) chk({tag, ".spurious"}, ov, 1'b0);
        else begin
          chk({tag, ".ctl"}, co3, q[0].ctl);
          chk({tag, ".res"}, res3, q[0].res);
          chk({tag, ".flg"}, flg3, q[0].flg);
          chk({tag, ".for"}, fo3, q[0].fo);
          chk({tag, ".msk"}, mo3, q[0].msk);
        end
      end
      @(posedge clk);
      if (v3 && ir) begin
        q.push_back(cur);
        sent++;
      end
      if (ov && r3) begin
        if (q.size() > 0) void'(q.pop_front());
        got++;
      end
      #1;
      cyc++;
      if (v3 && ir) begin
        if (sent < nb) drive_rand(16'(tag0 + 16'(sent)), cur);
        else v3 = 1'b0;
      end
    end
    v3 = 1'b0;
    r3 = 1'b1;
    chk({tag, ".count"}, got, nb);
    chk({tag, ".drained"}, q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t dummy;
    rst_n = 1'b0; v2 = 1'b0; v3 = 1'b0; r2 = 1'b1; r3 = 1'b1;
    a = '0; rm = '0; uns = 1'b0; msk = '0; ctl = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ov2", ov2, 1'b0);
    chk("rst.ov3", ov3, 1'b0);
    chk("rst.ir2", ir2, 1'b1);
    chk("rst.res2", res2, 128'd0);
    chk("rst.ctl3", co3, 16'd0);
    chk("rst.for2", fo2, 5'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    send2({96'd0, F1P5}, 3'd0, 1'b0, 4'b0001, 16'h0011, "rne1p5");
    chk("rne1p5.c", lres[31:0], 32'h2);   chk("rne1p5.f", lflg[4:0], 5'h01);
    send2({96'd0, F1P5}, 3'd1, 1'b0, 4'b0001, 16'h0012, "rtz1p5");
    chk("rtz1p5.c", lres[31:0], 32'h1);   chk("rtz1p5.f", lflg[4:0], 5'h01);
    send2({96'd0, FM2P5}, 3'd0, 1'b0, 4'b0001, 16'h0013, "rnem2p5");
    chk("rnem2p5.c", lres[31:0], 32'hFFFF_FFFE); chk("rnem2p5.f", lflg[4:0], 5'h01);
    send2({96'd0, FM2P5}, 3'd4, 1'b0, 4'b0001, 16'h0014, "rmmm2p5");
    chk("rmmm2p5.c", lres[31:0], 32'hFFFF_FFFD); chk("rmmm2p5.f", lflg[4:0], 5'h01);
    send2({96'd0, FNAN}, 3'd0, 1'b0, 4'b0001, 16'h0015, "nan");
    chk("nan.c", lres[31:0], 32'h7FFF_FFFF); chk("nan.f", lflg[4:0], 5'h10);
    send2({96'd0, F2P31}, 3'd0, 1'b0, 4'b0001, 16'h0016, "s2p31");
    chk("s2p31.c", lres[31:0], 32'h7FFF_FFFF); chk("s2p31.f", lflg[4:0], 5'h10);
    send2({96'd0, F2P31}, 3'd0, 1'b1, 4'b0001, 16'h0017, "u2p31");
    chk("u2p31.c", lres[31:0], 32'h8000_0000); chk("u2p31.f", lflg[4:0], 5'h00);
    send2({96'd0, FM1}, 3'd0, 1'b1, 4'b0001, 16'h0018, "um1");
    chk("um1.c", lres[31:0], 32'h0); chk("um1.f", lflg[4:0], 5'h10);
    send2({96'd0, FMQ}, 3'd1, 1'b1, 4'b0001, 16'h0019, "umq");
    chk("umq.c", lres[31:0], 32'h0); chk("umq.f", lflg[4:0], 5'h01);
    send2({32'h8000_0000, 32'h3FA0_0000, 32'hBFC0_0000, 32'h4EFF_FFFF}, 3'd3, 1'b0, 4'hF,
          16'h001A, "rup");
    chk("rup.l0", lres[31:0], 32'h7FFF_FF80);  chk("rup.l1", lres[63:32], 32'hFFFF_FFFF);
    chk("rup.l2", lres[95:64], 32'h2);         chk("rup.l3", lres[127:96], 32'h0);
    chk("rup.f3", lflg[19:15], 5'h00);         chk("rup.for", lfo, 5'h01);
    send2({FNAN, FM2P5, FNAN, F1P5}, 3'd0, 1'b0, 4'b0101, 16'hA5A5, "mask");
    chk("mask.l0", lres[31:0], 32'h2);         chk("mask.l1", lres[63:32], 32'h0);
    chk("mask.l2", lres[95:64], 32'hFFFF_FFFE); chk("mask.l3", lres[127:96], 32'h0);
    chk("mask.f1", lflg[9:5], 5'h00);          chk("mask.f3", lflg[19:15], 5'h00);
    chk("mask.for", lfo, 5'h01);               chk("mask.ctl", lco, 16'hA5A5);
    chk("mask.mo", lmo, 4'b0101);

    for (int i = 0; i < 8; i++)
      send2({rand_fp(), rand_fp(), rand_fp(), rand_fp()}, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom), "rnd2");

    stream3(6, 2, 5, 1'b0, 16'd1, "bp");
    stream3(40, 0, 0, 1'b1, 16'h0100, "rnd3");

    @(posedge clk); #1;
    drive_rand(16'hDEAD, dummy); r3 = 1'b1; v3 = 1'b1;
    @(posedge clk); #1 ctl = 16'hBEEF;
    @(posedge clk); #1 v3 = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rst2.ir", ir3, 1'b1);
    chk("rst2.ov_pre", ov3, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst2.ov", ov3, 1'b0);
    chk("rst2.res", res3, 128'd0);
    chk("rst2.ctl", co3, 16'd0);
    chk("rst2.for", fo3, 5'd0);
    chk("rst2.mo", mo3, 4'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst2.drop", ov3, 1'b0);
    end
    stream3(1, 0, 0, 1'b0, 16'h0777, "post");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fp_to_int_vec.md
Name: fp_to_int_vec

Overview:
- Multi-lane, parametrised-latency FP32 to INT32/UINT32 converter for the SM FPU pipeline.
- Converts NUM_LANES operands per beat, with per-lane activity mask, per-lane RISC-V fflags, and a pass-through control tag.
- Uses a stallable valid/ready pipeline of LATENCY stages, with full throughput and no bubbles under continuous ready.
- Successor to the single-lane two-stage converter: lane count, depth and control width are generalised; unsigned conversion and lane masking are added.

Parameters:
- NUM_LANES, 4, number of independent conversion lanes.
- LATENCY, 2, pipeline stages from input acceptance to output valid; legal range 1..8.
- CTRL_WIDTH, 16, width of the opaque control tag (regindex, warpid, wvd, wxd packed by the caller).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when in_valid_i && in_ready_o.
- a_i  in  32*NUM_LANES  FP32 operands; lane k is a_i[32k+31:32k].
- rm_i  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 behave as RNE.
- unsigned_i  in  1  0 = signed int32 result, 1 = uint32 result.
- mask_i  in  NUM_LANES  lane active bits.
- ctrl_i  in  CTRL_WIDTH  tag, carried unchanged to the output.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream ready.
- result_o  out  32*NUM_LANES  per-lane integer results.
- fflags_o  out  5*NUM_LANES  per-lane {NV,DZ,OF,UF,NX}.
- fflags_or_o  out  5  OR of fflags_o over active lanes.
- mask_o  out  NUM_LANES  registered mask_i.
- ctrl_o  out  CTRL_WIDTH  registered ctrl_i.

Behaviour:
- Reset is synchronous on clk when rst_n=0.
  - All stage valid bits clear.
  - All data registers clear.
  - All outputs are 0 one cycle later.
  - in_ready_o is 1 while in reset.
  - A beat in flight during reset is dropped; no output is produced for it.
- Pipeline: stage s holds valid_s.
  - adv_LATENCY = !valid_LATENCY || out_ready_i.
  - adv_s = !valid_s || adv_{s+1}.
  - in_ready_o = adv_1.
  - A stage loads from its predecessor only when adv_s is 1; otherwise it holds.
  - valid_1 loads in_valid_i; valid_s loads valid_{s-1}.
  - Accepted beat appears on the outputs exactly LATENCY cycles later if never stalled.
  - Outputs hold stable while out_valid_o && !out_ready_i.
  - No beat is lost or duplicated.
- Conversion is combinational on stage-1 input data and is registered into stage 1; stages 2..LATENCY are delay registers.
- Per-lane conversion, exponent e, unbiased E = e-127:
  - NaN (e=255, frac≠0): signed → 0x7FFFFFFF; unsigned → 0xFFFFFFFF; NV.
  - ±Inf: signed +→0x7FFFFFFF, −→0x80000000; unsigned +→0xFFFFFFFF, −→0x00000000; NV.
  - Finite value: round magnitude to an integer per rm. RDN/RUP are applied with respect to sign. RMM rounds ties away from zero.
  - Overflow:
    - Signed result > 2^31−1 → 0x7FFFFFFF, NV.
    - Signed result < −2^31 → 0x80000000, NV.
    - Unsigned result > 2^32−1 → 0xFFFFFFFF, NV.
    - Unsigned result with rounded value negative nonzero → 0x00000000, NV.
    - NX is not set when NV is set.
  - Unsigned input negative but rounding to 0 → 0, NX only (if inexact).
  - Otherwise NX = 1 iff any discarded fraction bit is 1.
  - DZ, OF, UF are always 0.
  - Subnormals and ±0 are treated as finite. ±0 → 0 with no flags.
- Masked-off lanes: result 0, fflags 0, excluded from fflags_or_o.
- unsigned_i, rm_i, mask_i and ctrl_i are sampled with the beat; they travel with it and never mix between beats.

Test Plan:
- LATENCY=2, out_ready=1, lane0 0x3FC00000 (1.5), rm=RNE, signed → result 0x00000002, fflags 0x01, out_valid exactly 2 cycles after accept.
- Same input, rm=RTZ → 0x00000001, NX; −2.5 (0xC0200000) with RNE → 0xFFFFFFFE, NX; with RMM → 0xFFFFFFFD, NX.
- Special values, signed: NaN 0x7FC00000 → 0x7FFFFFFF, fflags 0x10; 0x4F000000 (2^31) → 0x7FFFFFFF, NV.
- Special values, unsigned: 0x4F000000 → 0x80000000, no flags; −1.0 (0xBF800000) → 0, NV; −0.25 (0xBE800000) RTZ → 0, NX only.
- Mask and tag: mask=4'b0101, lanes 1 and 3 carry NaN → those lanes give result 0 and fflags 0; fflags_or_o reflects lanes 0 and 2 only; ctrl_o equals ctrl_i of the same beat.
- Backpressure: LATENCY=3, stream 6 beats with tags 1..6, out_ready=0 for 5 cycles mid-stream.
  - in_ready_o drops once 3 beats are held.
  - Outputs hold stable while stalled.
  - Tags emerge 1..6 in order with no gaps or duplicates.
- Reset: assert rst_n=0 for one cycle with 2 beats in flight → out_valid_o=0 the next cycle; neither beat ever appears; a new beat after reset completes normally.
